midi_in: RTL and testbench
==========================

Name: midi_in

Overview:
- Receives a MIDI serial stream at 31250 baud and decodes Note On and Note Off messages, including running status.
- Queues decoded events in a small FIFO.
- Presents each event to the downstream player stage as an 8-bit msg {on, note[6:0]} with a slow clk_msg strobe; the player detects the strobe's rising edge.
- Sits directly upstream of player, between the board MIDI-in pin and player's msg/clk_msg inputs.

Parameters:
- CLK_FREQ, 120_000_000: system clock frequency in Hz.
- BAUD, 31250: serial bit rate. BIT_DIV = CLK_FREQ/BAUD (3840 at defaults).
- CHANNEL, 16: MIDI channel filter. 0..15 accepts that channel only; 16 accepts all channels (omni).
- FIFO_DEPTH, 8: event FIFO entries. Must be a power of 2, at least 2.
- STROBE_HIGH, 32: cycles clk_msg is held high per event.
- STROBE_LOW, 32: minimum cycles clk_msg is held low after each event. Must be at least downstream PLAYER_NUM+2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- midi_rx  in  1  raw serial input. Idle high; asynchronous to clk.
- msg  out  8  event. Bit 7: 1 = note on, 0 = note off. Bits 6:0: MIDI note number.
- clk_msg  out  1  event strobe. Downstream samples msg on its rising edge.
- frame_err  out  1  one-cycle pulse when a received byte has a bad stop bit.
- overflow  out  1  one-cycle pulse when a decoded event is dropped because the FIFO is full.

Behaviour:
- Reset: while rst=0, all outputs are 0 immediately; FIFO is emptied; all FSMs return to idle; running status is cleared. An event strobe in progress is abandoned (clk_msg drops at once).
- UART receiver:
  - midi_rx passes through a 2-flop synchronizer.
  - A falling edge while idle starts a receive. The line is re-checked at BIT_DIV/2; if high, this is a false start and the receiver returns to idle.
  - 8 data bits are sampled LSB-first at BIT_DIV intervals from that mid-bit point.
  - The stop bit is sampled once. If it is 1, the receiver issues a one-cycle byte_valid with the data. If it is 0, the receiver pulses frame_err, discards the byte, and waits for the line to return high before re-arming.
- Parser FSM (states S_STATUS, S_NOTE, S_VEL, S_SKIP):
  - 0xF8..0xFF (real-time) are ignored in every state; state and running status are unchanged.
  - Status 0x8n/0x9n with a matching channel: latch the type and go to S_NOTE. With a non-matching channel, or any other status 0x80..0xF7: go to S_SKIP and clear running status.
  - S_NOTE receiving a data byte (<0x80): latch the note, go to S_VEL.
  - S_VEL receiving a data byte: emit an event, return to S_NOTE (running status).
  - A status byte arriving in S_NOTE or S_VEL aborts the partial message and is processed as a new status byte.
  - S_SKIP and S_STATUS discard data bytes.
  - Event encoding: 0x9n with velocity>0 gives on=1. 0x9n with velocity 0, or 0x8n with any velocity, gives on=0.
  - Events with note 0 are dropped; downstream uses 0 as its empty-slot marker.
- FIFO:
  - An emitted event is pushed in the same cycle. When full, the event is dropped and overflow pulses.
  - Push and pop in the same cycle while full: both succeed.
  - No bypass: an event pushed into an empty FIFO can be popped no earlier than the next cycle.
- Strobe FSM (states T_IDLE, T_SETUP, T_HIGH, T_LOW):
  - T_IDLE with FIFO not empty: pop, load msg, go to T_SETUP. msg is now stable one cycle before clk_msg rises.
  - T_SETUP lasts 1 cycle, then clk_msg=1 and the FSM enters T_HIGH.
  - T_HIGH lasts STROBE_HIGH cycles, then clk_msg=0 and the FSM enters T_LOW.
  - T_LOW lasts STROBE_LOW cycles, then the FSM returns to T_IDLE.
  - msg holds its value until the next pop.
  - Event-to-event spacing is at least 1+STROBE_HIGH+STROBE_LOW+1 cycles.
- Latency: clk_msg rises 3 cycles after the event push when the FIFO was empty and the FSM was in T_IDLE.

Decomposition:
- Shared package: MIDI status nibbles (NOTE_OFF=4'h8, NOTE_ON=4'h9), real-time threshold 8'hF8, msg field positions (ON_BIT=7, NOTE_MSB=6), and the omni channel code 16.
- One sub-module: midi_uart_rx (synchronizer, bit timing, byte_valid/frame_err).
- Parser, FIFO and strobe logic stay in midi_in.

Test Plan:
- Bytes 0x90,0x3C,0x64 -> one event: msg=0xBC, clk_msg high for exactly 32 cycles, then low for at least 32 cycles; frame_err=overflow=0.
- Bytes 0x90,0x3C,0x64,0x40,0x00 (running status) -> two events, msg=0xBC then msg=0x40; strobes separated by at least 66 cycles.
- Bytes 0x80,0xF8,0x3C,0xFE,0x40 (real-time bytes interleaved) -> single event msg=0x3C.
- Byte 0x90 sent with stop bit=0 -> one frame_err pulse, no event. A following 0x91,0x3C,0x64 with CHANNEL=0 gives no event; with CHANNEL=16 gives msg=0xBC.
- STROBE_HIGH=STROBE_LOW=2_000_000, ten note-on events sent back-to-back -> first event is presented, next 8 are queued, 10th raises one overflow pulse; the 9 accepted events emerge in order.
- rst=0 asserted mid-T_HIGH -> clk_msg=0 and msg=0 in the same cycle, FIFO empty. After release, 0x90,0x3C,0x64 decodes normally to msg=0xBC.

Source files
------------

// File: rtl/midi_in_pkg.sv
// Shared constants and types for the MIDI note receiver.
// Holds status nibbles, message field positions and the FSM state encodings.
package midi_in_pkg;

    localparam logic [3:0]  NOTE_OFF = 4'h8;
    localparam logic [3:0]  NOTE_ON  = 4'h9;
    localparam logic [7:0]  RT_MIN   = 8'hF8;
    localparam int          ON_BIT   = 7;
    localparam int          NOTE_MSB = 6;
    localparam int unsigned OMNI     = 16;

    typedef enum logic [1:0] {S_STATUS, S_NOTE, S_VEL, S_SKIP} parse_state_e;
    typedef enum logic [1:0] {T_IDLE, T_SETUP, T_HIGH, T_LOW} strobe_state_e;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_e;

    function automatic logic chan_match(input logic [3:0] ch, input int unsigned sel);
        return (sel == OMNI) || (ch == sel[3:0]);
    endfunction

endpackage

// File: rtl/midi_in_if.sv
// Event interface between midi_in and the downstream player stage.
// The master drives the message, its strobe and the error pulses.
interface midi_in_if;
    logic [7:0] msg;
    logic       clk_msg;
    logic       frame_err;
    logic       overflow;

    modport master (output msg, output clk_msg, output frame_err, output overflow);
    modport slave  (input msg, input clk_msg, input frame_err, input overflow);
endinterface

// File: rtl/midi_uart_rx.sv
// 8N1 serial receiver: synchronizer, mid-bit sampling, byte_valid and frame_err pulses.
// After a bad stop bit it waits for the line to go high before re-arming.
module midi_uart_rx
    import midi_in_pkg::*;
#(
    parameter int unsigned BIT_DIV = 3840
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o
);

    localparam int unsigned CW = $clog2(BIT_DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(BIT_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BIT_DIV - 1);

    logic            rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            R_IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_s2_q) state_d = R_START;
            end
            R_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // A line that is high again at mid start bit was a glitch.
                    state_d = rx_s2_q ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = R_STOP;
                end
            end
            R_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s2_q) begin
                        valid_d = 1'b1;
                        state_d = R_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                cnt_d = '0;
                if (rx_s2_q) state_d = R_IDLE;
            end
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= R_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_s1_q   <= rx_i;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    assign data_o      = shift_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;

endmodule

// File: rtl/midi_in.sv
// MIDI-in front end: decodes Note On/Off (with running status) into {on, note} events,
// queues them and presents each one to the player with a slow clk_msg strobe.
module midi_in
    import midi_in_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 120_000_000,
    parameter int unsigned BAUD        = 31_250,
    parameter int unsigned CHANNEL     = 16,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned STROBE_HIGH = 32,
    parameter int unsigned STROBE_LOW  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        midi_rx,
    midi_in_if.master   mif
);

    localparam int unsigned BIT_DIV = CLK_FREQ / BAUD;
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned TMAX    = (STROBE_HIGH > STROBE_LOW) ? STROBE_HIGH : STROBE_LOW;
    localparam int unsigned TW      = $clog2(TMAX + 1);

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ferr;

    midi_uart_rx #(
        .BIT_DIV(BIT_DIV)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx_i       (midi_rx),
        .data_o     (rx_data),
        .valid_o    (rx_valid),
        .frame_err_o(rx_ferr)
    );

    // Parser
    parse_state_e pstate_q, pstate_d;
    logic         type_on_q, type_on_d;
    logic [6:0]   note_q, note_d;
    logic         is_note_status;
    logic         push;
    logic [7:0]   ev;

    always_comb begin
        pstate_d       = pstate_q;
        type_on_d      = type_on_q;
        note_d         = note_q;
        push           = 1'b0;
        ev             = '0;
        is_note_status = (rx_data[7:4] == NOTE_ON || rx_data[7:4] == NOTE_OFF) &&
                         chan_match(rx_data[3:0], CHANNEL);
        if (rx_valid && rx_data < RT_MIN) begin
            if (rx_data[7]) begin
                // Any status aborts a partial message; unknown ones also drop running status.
                pstate_d  = is_note_status ? S_NOTE : S_SKIP;
                type_on_d = (rx_data[7:4] == NOTE_ON);
            end else begin
                unique case (pstate_q)
                    S_NOTE: begin
                        note_d   = rx_data[6:0];
                        pstate_d = S_VEL;
                    end
                    S_VEL: begin
                        pstate_d         = S_NOTE;
                        push             = (note_q != 7'd0);
                        ev[ON_BIT]       = type_on_q && (rx_data[6:0] != 7'd0);
                        ev[NOTE_MSB:0]   = note_q;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pstate_q  <= S_STATUS;
            type_on_q <= 1'b0;
            note_q    <= '0;
        end else begin
            pstate_q  <= pstate_d;
            type_on_q <= type_on_d;
            note_q    <= note_d;
        end
    end

    // Event FIFO; pointers carry one extra wrap bit to tell full from empty.
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic        full, empty, pop, push_ok;
    logic        overflow_q, overflow_d;
    strobe_state_e tstate_q;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop     = (tstate_q == T_IDLE) && !empty;
    assign push_ok = push && (!full || pop);

    always_comb begin
        wr_d       = push_ok ? wr_q + (AW + 1)'(1) : wr_q;
        rd_d       = pop ? rd_q + (AW + 1)'(1) : rd_q;
        overflow_d = push && !push_ok;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= ev;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q       <= '0;
            rd_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            overflow_q <= overflow_d;
        end
    end

    // Strobe FSM
    logic [7:0]    msg_q;
    logic          clk_msg_q;
    logic [TW-1:0] tcnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tstate_q  <= T_IDLE;
            msg_q     <= '0;
            clk_msg_q <= 1'b0;
            tcnt_q    <= '0;
        end else begin
            unique case (tstate_q)
                T_IDLE: begin
                    if (pop) begin
                        msg_q    <= mem_q[rd_q[AW-1:0]];
                        tstate_q <= T_SETUP;
                    end
                end
                T_SETUP: begin
                    clk_msg_q <= 1'b1;
                    tcnt_q    <= '0;
                    tstate_q  <= T_HIGH;
                end
                T_HIGH: begin
                    if (tcnt_q == TW'(STROBE_HIGH - 1)) begin
                        clk_msg_q <= 1'b0;
                        tcnt_q    <= '0;
                        tstate_q  <= T_LOW;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                T_LOW: begin
                    if (tcnt_q == TW'(STROBE_LOW - 1)) begin
                        tcnt_q   <= '0;
                        tstate_q <= T_IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                default: tstate_q <= T_IDLE;
            endcase
        end
    end

    assign mif.msg       = msg_q;
    assign mif.clk_msg   = clk_msg_q;
    assign mif.frame_err = rx_ferr;
    assign mif.overflow  = overflow_q;

endmodule

// File: tb/tb_midi_in.sv
// Bench for midi_in: three instances (omni, channel 0, long-strobe omni) driven by serial
// frames, compared against a byte-level model of the Note On/Off decoding rules.
module tb_midi_in;

    localparam int DIV_AB = 16;
    localparam int DIV_C  = 8;
    localparam int HI_AB  = 32;
    localparam int LO_AB  = 32;
    localparam int HI_C   = 1000;

    typedef struct {
        int         dut;
        logic [7:0] msg;
        int         hi;
        int         gap;
        bit         setup_ok;
    } ev_t;
    typedef struct {
        int         dut;
        logic [7:0] msg;
    } exp_t;
    typedef logic [7:0] msgq_t[$];
    typedef ev_t evq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx_ab = 1'b1;
    logic rx_c = 1'b1;

    int checks = 0;
    int errors = 0;

    midi_in_if ifa ();
    midi_in_if ifb ();
    midi_in_if ifc ();

    midi_in #(.CLK_FREQ(500_000), .BAUD(31_250), .CHANNEL(16), .FIFO_DEPTH(8),
              .STROBE_HIGH(HI_AB), .STROBE_LOW(LO_AB))
        dut_a (.clk(clk), .rst(rst), .midi_rx(rx_ab), .mif(ifa));
    midi_in #(.CLK_FREQ(500_000), .BAUD(31_250), .CHANNEL(0), .FIFO_DEPTH(8),
              .STROBE_HIGH(HI_AB), .STROBE_LOW(LO_AB))
        dut_b (.clk(clk), .rst(rst), .midi_rx(rx_ab), .mif(ifb));
    midi_in #(.CLK_FREQ(250_000), .BAUD(31_250), .CHANNEL(16), .FIFO_DEPTH(8),
              .STROBE_HIGH(HI_C), .STROBE_LOW(HI_C))
        dut_c (.clk(clk), .rst(rst), .midi_rx(rx_c), .mif(ifc));

    always #5 clk = ~clk;

    logic [2:0] cm, fe, ov;
    logic [7:0] mg [3];
    assign cm = {ifc.clk_msg, ifb.clk_msg, ifa.clk_msg};
    assign fe = {ifc.frame_err, ifb.frame_err, ifa.frame_err};
    assign ov = {ifc.overflow, ifb.overflow, ifa.overflow};
    assign mg[0] = ifa.msg;
    assign mg[1] = ifb.msg;
    assign mg[2] = ifc.msg;

    // Monitor: records each completed strobe with its width and preceding low time.
    ev_t        ev_q[$];
    int         fe_c[3], ov_c[3], hi_c[3], lo_c[3], pend_gap[3];
    logic [7:0] pend_msg[3], mg_p[3];
    bit         pend_ok[3], armed[3];
    logic [2:0] cm_p;

    initial begin
        cm_p = '0;
        for (int d = 0; d < 3; d++) begin
            fe_c[d] = 0; ov_c[d] = 0; hi_c[d] = 0; lo_c[d] = 1000000; armed[d] = 0;
            mg_p[d] = '0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (!rst) begin
                    hi_c[d] = 0; lo_c[d] = 1000000; armed[d] = 0;
                end else begin
                    if (cm[d] && !cm_p[d]) begin
                        pend_msg[d] = mg[d];
                        pend_ok[d]  = (mg_p[d] == mg[d]);
                        pend_gap[d] = lo_c[d];
                        hi_c[d]     = 1;
                        armed[d]    = 1;
                    end else if (cm[d]) begin
                        hi_c[d]++;
                    end else if (cm_p[d]) begin
                        if (armed[d]) begin
                            ev_t e;
                            e.dut = d; e.msg = pend_msg[d]; e.hi = hi_c[d];
                            e.gap = pend_gap[d]; e.setup_ok = pend_ok[d];
                            ev_q.push_back(e);
                        end
                        armed[d] = 0;
                        lo_c[d]  = 1;
                    end else begin
                        lo_c[d]++;
                    end
                    if (fe[d]) fe_c[d]++;
                    if (ov[d]) ov_c[d]++;
                end
                cm_p[d] = cm[d];
                mg_p[d] = mg[d];
            end
        end
    end

    // Reference model: running status byte plus an optional pending note per instance.
    int         m_ch[3] = '{16, 0, 16};
    logic [7:0] m_stat[3] = '{8'h00, 8'h00, 8'h00};
    int         m_note[3] = '{-1, -1, -1};
    exp_t       exp_q[$];

    function automatic void model_feed(input int d, input logic [7:0] b);
        exp_t e;
        int   ch;
        ch = m_ch[d];
        if (b >= 8'hF8) return;
        if (b >= 8'h80) begin
            if ((b[7:4] == 4'h8 || b[7:4] == 4'h9) && (ch == 16 || int'(b[3:0]) == ch))
                m_stat[d] = b;
            else
                m_stat[d] = 8'h00;
            m_note[d] = -1;
            return;
        end
        if (m_stat[d] == 8'h00) return;
        if (m_note[d] < 0) begin
            m_note[d] = int'(b);
        end else begin
            if (m_note[d] != 0) begin
                e.dut = d;
                e.msg = {(m_stat[d][7:4] == 4'h9) && (b != 8'h00), 7'(m_note[d])};
                exp_q.push_back(e);
            end
            m_note[d] = -1;
        end
    endfunction

    function automatic msgq_t exp_of(input int d);
        msgq_t r;
        foreach (exp_q[i]) if (exp_q[i].dut == d) r.push_back(exp_q[i].msg);
        return r;
    endfunction

    function automatic evq_t obs_of(input int d);
        evq_t r;
        foreach (ev_q[i]) if (ev_q[i].dut == d) r.push_back(ev_q[i]);
        return r;
    endfunction

    task automatic clear_all();
        ev_q.delete();
        exp_q.delete();
        for (int d = 0; d < 3; d++) begin
            fe_c[d] = 0;
            ov_c[d] = 0;
        end
    endtask

    task automatic send(input int line, input logic [7:0] b, input bit stop);
        logic [9:0] frame;
        int         div;
        div   = (line == 0) ? DIV_AB : DIV_C;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (line == 0) rx_ab = frame[i]; else rx_c = frame[i];
            repeat (div) @(negedge clk);
        end
        if (line == 0) rx_ab = 1'b1; else rx_c = 1'b1;
        if (!stop) begin
            repeat (3 * div) @(negedge clk);
        end else if (line == 0) begin
            model_feed(0, b);
            model_feed(1, b);
        end else begin
            model_feed(2, b);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (5) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (cm[d] !== 1'b0) begin
                errors++; $display("FAIL reset_clk_msg dut%0d: got %b want 0", d, cm[d]);
            end
            checks++;
            if (mg[d] !== 8'h00) begin
                errors++; $display("FAIL reset_msg dut%0d: got %h want 00", d, mg[d]);
            end
            checks++;
            if (fe[d] !== 1'b0 || ov[d] !== 1'b0) begin
                errors++; $display("FAIL reset_pulses dut%0d: got fe=%b ov=%b want 0 0", d, fe[d], ov[d]);
            end
        end
        rst = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single();
        evq_t o;
        clear_all();
        send(0, 8'h90, 1); send(0, 8'h3C, 1); send(0, 8'h64, 1);
        repeat (400) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            o = obs_of(d);
            checks++;
            if (o.size() !== 1) begin
                errors++; $display("FAIL single_count dut%0d: got %0d want 1", d, o.size());
            end else begin
                checks++;
                if (o[0].msg !== 8'hBC) begin
                    errors++; $display("FAIL single_msg dut%0d: got %h want bc", d, o[0].msg);
                end
                checks++;
                if (o[0].hi !== HI_AB) begin
                    errors++; $display("FAIL single_high dut%0d: got %0d want %0d", d, o[0].hi, HI_AB);
                end
                checks++;
                if (o[0].setup_ok !== 1'b1) begin
                    errors++; $display("FAIL single_setup dut%0d: got 0 want 1", d);
                end
            end
            checks++;
            if (lo_c[d] < LO_AB) begin
                errors++; $display("FAIL single_low dut%0d: got %0d want >=%0d", d, lo_c[d], LO_AB);
            end
            checks++;
            if (fe_c[d] !== 0 || ov_c[d] !== 0) begin
                errors++; $display("FAIL single_pulses dut%0d: got fe=%0d ov=%0d want 0 0", d, fe_c[d], ov_c[d]);
            end
        end
    endtask

    task automatic test_running();
        evq_t o;
        clear_all();
        send(0, 8'h90, 1); send(0, 8'h3C, 1); send(0, 8'h64, 1);
        send(0, 8'h40, 1); send(0, 8'h00, 1);
        repeat (400) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            o = obs_of(d);
            checks++;
            if (o.size() !== 2) begin
                errors++; $display("FAIL running_count dut%0d: got %0d want 2", d, o.size());
            end else begin
                checks++;
                if (o[0].msg !== 8'hBC || o[1].msg !== 8'h40) begin
                    errors++; $display("FAIL running_msgs dut%0d: got %h %h want bc 40", d, o[0].msg, o[1].msg);
                end
                checks++;
                if (o[1].gap < LO_AB || o[0].hi + o[1].gap < HI_AB + LO_AB + 2) begin
                    errors++; $display("FAIL running_spacing dut%0d: got hi=%0d gap=%0d want spacing>=%0d",
                                       d, o[0].hi, o[1].gap, HI_AB + LO_AB + 2);
                end
            end
        end
    endtask

    task automatic test_realtime();
        evq_t o;
        clear_all();
        send(0, 8'h80, 1); send(0, 8'hF8, 1); send(0, 8'h3C, 1);
        send(0, 8'hFE, 1); send(0, 8'h40, 1);
        repeat (400) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            o = obs_of(d);
            checks++;
            if (o.size() !== 1 || (o.size() > 0 && o[0].msg !== 8'h3C)) begin
                errors++; $display("FAIL realtime dut%0d: got count=%0d first=%h want 1 3c", d,
                                   o.size(), (o.size() > 0) ? o[0].msg : 8'hxx);
            end
        end
    endtask

    task automatic test_frame_err();
        evq_t o;
        clear_all();
        send(0, 8'h90, 0);
        repeat (100) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (fe_c[d] !== 1) begin
                errors++; $display("FAIL frame_err_pulses dut%0d: got %0d want 1", d, fe_c[d]);
            end
            o = obs_of(d);
            checks++;
            if (o.size() !== 0) begin
                errors++; $display("FAIL frame_err_event dut%0d: got %0d want 0", d, o.size());
            end
        end
        clear_all();
        send(0, 8'h91, 1); send(0, 8'h3C, 1); send(0, 8'h64, 1);
        repeat (400) @(negedge clk);
        o = obs_of(0);
        checks++;
        if (o.size() !== 1 || (o.size() > 0 && o[0].msg !== 8'hBC)) begin
            errors++; $display("FAIL chan_omni: got count=%0d first=%h want 1 bc", o.size(),
                               (o.size() > 0) ? o[0].msg : 8'hxx);
        end
        o = obs_of(1);
        checks++;
        if (o.size() !== 0) begin
            errors++; $display("FAIL chan_filter: got %0d events want 0", o.size());
        end
    endtask

    task automatic test_random();
        evq_t       o;
        msgq_t      e;
        logic [7:0] b;
        int         r;
        clear_all();
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4)       b = (($urandom_range(0, 1) != 0) ? 8'h90 : 8'h80) | 8'($urandom_range(0, 2));
            else if (r == 4) b = 8'($urandom_range(8'hA0, 8'hF7));
            else if (r == 5) b = 8'($urandom_range(8'hF8, 8'hFF));
            else if (r == 6) b = 8'h00;
            else             b = 8'($urandom_range(0, 127));
            send(0, b, 1);
        end
        repeat (400) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            o = obs_of(d);
            e = exp_of(d);
            checks++;
            if (o.size() !== e.size()) begin
                errors++; $display("FAIL random_count dut%0d: got %0d want %0d", d, o.size(), e.size());
            end
            for (int i = 0; i < o.size() && i < e.size(); i++) begin
                checks++;
                if (o[i].msg !== e[i] || o[i].hi !== HI_AB || o[i].gap < LO_AB) begin
                    errors++; $display("FAIL random_event dut%0d #%0d: got msg=%h hi=%0d gap=%0d want msg=%h hi=%0d gap>=%0d",
                                       d, i, o[i].msg, o[i].hi, o[i].gap, e[i], HI_AB, LO_AB);
                end
            end
            checks++;
            if (ov_c[d] !== 0 || fe_c[d] !== 0) begin
                errors++; $display("FAIL random_pulses dut%0d: got ov=%0d fe=%0d want 0 0", d, ov_c[d], fe_c[d]);
            end
        end
    endtask

    task automatic test_overflow();
        evq_t  o;
        msgq_t e;
        clear_all();
        send(1, 8'h90, 1);
        for (int i = 0; i < 10; i++) begin
            send(1, 8'($urandom_range(1, 127)), 1);
            send(1, 8'($urandom_range(1, 127)), 1);
        end
        repeat (9 * (HI_C * 2 + 2) + 500) @(negedge clk);
        o = obs_of(2);
        e = exp_of(2);
        checks++;
        if (ov_c[2] !== 1) begin
            errors++; $display("FAIL overflow_pulses: got %0d want 1", ov_c[2]);
        end
        checks++;
        if (o.size() !== 9 || e.size() !== 10) begin
            errors++; $display("FAIL overflow_count: got %0d want 9 (model %0d sent)", o.size(), e.size());
        end
        for (int i = 0; i < o.size() && i < 9 && i < e.size(); i++) begin
            checks++;
            if (o[i].msg !== e[i] || o[i].hi !== HI_C) begin
                errors++; $display("FAIL overflow_order #%0d: got msg=%h hi=%0d want msg=%h hi=%0d",
                                   i, o[i].msg, o[i].hi, e[i], HI_C);
            end
        end
    endtask

    task automatic test_reset_mid_strobe();
        evq_t o;
        int   t;
        clear_all();
        send(0, 8'h90, 1); send(0, 8'h3C, 1); send(0, 8'h64, 1);
        t = 0;
        while (!cm[0] && t < 2000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (cm[0] !== 1'b1) begin
            errors++; $display("FAIL mid_reset_strobe_seen: got %b want 1", cm[0]);
        end
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (cm[0] !== 1'b0 || mg[0] !== 8'h00) begin
            errors++; $display("FAIL mid_reset_outputs: got clk_msg=%b msg=%h want 0 00", cm[0], mg[0]);
        end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            m_stat[d] = 8'h00;
            m_note[d] = -1;
        end
        clear_all();
        repeat (300) @(negedge clk);
        o = obs_of(0);
        checks++;
        if (o.size() !== 0) begin
            errors++; $display("FAIL mid_reset_fifo_empty: got %0d events want 0", o.size());
        end
        send(0, 8'h90, 1); send(0, 8'h3C, 1); send(0, 8'h64, 1);
        repeat (400) @(negedge clk);
        o = obs_of(0);
        checks++;
        if (o.size() !== 1 || (o.size() > 0 && o[0].msg !== 8'hBC)) begin
            errors++; $display("FAIL mid_reset_recover: got count=%0d first=%h want 1 bc", o.size(),
                               (o.size() > 0) ? o[0].msg : 8'hxx);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_running();
        test_realtime();
        test_frame_err();
        test_random();
        test_overflow();
        test_reset_mid_strobe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
